dcache_ctrl: RTL



---
 rtl/dcache_pkg.sv | 34 +++
 rtl/dcache_arrays.sv | 57 +++++
 rtl/dcache_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and derived sizes for the two-way set-associative data cache.
// Array geometry is fixed here; the controller's parameters default to these values.
package dcache_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_SET_BITS   = 4;
   localparam int TAG_BITS       = DEF_ADDR_WIDTH - DEF_SET_BITS - 2;
   localparam int SETS           = 1 << DEF_SET_BITS;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_FILL  = 2'd1;
   localparam state_t ST_WTHRU = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   // "use" is a reserved word, so the recency bit is called used
   typedef struct packed {
      logic                      valid;
      logic                      used;
      logic [TAG_BITS-1:0]       tag;
      logic [DEF_DATA_WIDTH-1:0] data;
   } cache_entry_t;

   typedef struct packed {
      cache_entry_t [1:0] way;
   } cache_set_t;

   // Invalid way first (way 0 before way 1), else the way with used=0, else way 0
   function automatic logic pick_victim(input cache_set_t s);
      return s.way[0].valid && (!s.way[1].valid || (s.way[0].used && !s.way[1].used));
   endfunction

endpackage

// File: rtl/dcache_arrays.sv
// Tag/valid/use/data storage for both ways: combinational read by set,
// clocked line write with way select, and a separate recency update port.
module dcache_arrays
   import dcache_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DEF_SET_BITS-1:0]   rd_set,
   output cache_set_t                rd_data,
   input  logic                      wr_en,
   input  logic                      wr_way,
   input  logic [DEF_SET_BITS-1:0]   wr_set,
   input  logic [TAG_BITS-1:0]       wr_tag,
   input  logic [DEF_DATA_WIDTH-1:0] wr_data,
   input  logic                      use_en,
   input  logic                      use_way,
   input  logic [DEF_SET_BITS-1:0]   use_set
);

   logic [SETS-1:0]           valid_q [2];
   logic [SETS-1:0]           used_q  [2];
   logic [TAG_BITS-1:0]       tag_mem  [2][SETS];
   logic [DEF_DATA_WIDTH-1:0] data_mem [2][SETS];

   always_comb begin
      for (int w = 0; w < 2; w++) begin
         rd_data.way[w].valid = valid_q[w][rd_set];
         rd_data.way[w].used  = used_q[w][rd_set];
         rd_data.way[w].tag   = tag_mem[w][rd_set];
         rd_data.way[w].data  = data_mem[w][rd_set];
      end
   end

   // Only the state bits need reset; tag and data are meaningless while invalid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         used_q[0]  <= '0;
         used_q[1]  <= '0;
      end else begin
         if (wr_en) valid_q[wr_way][wr_set] <= 1'b1;
         if (use_en) begin
            used_q[use_way][use_set]  <= 1'b1;
            used_q[~use_way][use_set] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_way][wr_set]  <= wr_tag;
         data_mem[wr_way][wr_set] <= wr_data;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache sequencer: one-cycle hits, read-miss line fills and write-through
// stores over a single-outstanding memory port.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SET_BITS   = DEF_SET_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  hit,
   output logic                  miss,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_t                     state;
   cache_set_t                 set_rd;
   logic [SET_BITS-1:0]        req_set, lat_set, rd_set;
   logic [TAG_BITS-1:0]        req_tag, lat_tag;
   logic                       hit_way0, hit_way1, hit_any, hit_way, victim;
   logic                       accept, fill_done;
   logic                       wr_en, wr_way, use_en, use_way;
   logic [SET_BITS-1:0]        wr_set, use_set;
   logic [TAG_BITS-1:0]        wr_tag;
   logic [DATA_WIDTH-1:0]      wr_data;
   logic                       unused_addr_bits;

   assign unused_addr_bits = ^req_addr[1:0];

   // The word-aligned mem_addr register doubles as the latched request address
   assign req_set = req_addr[SET_BITS+1:2];
   assign req_tag = req_addr[ADDR_WIDTH-1:SET_BITS+2];
   assign lat_set = mem_addr[SET_BITS+1:2];
   assign lat_tag = mem_addr[ADDR_WIDTH-1:SET_BITS+2];
   assign rd_set  = (state == ST_IDLE) ? req_set : lat_set;

   assign hit_way0  = set_rd.way[0].valid && (set_rd.way[0].tag == req_tag);
   assign hit_way1  = set_rd.way[1].valid && (set_rd.way[1].tag == req_tag);
   assign hit_any   = hit_way0 || hit_way1;
   assign hit_way   = !hit_way0;
   assign victim    = pick_victim(set_rd);

   assign req_ready = rst_n && (state == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign fill_done = (state == ST_FILL) && mem_ack;
   assign hit       = accept && hit_any;
   assign miss      = accept && !hit_any;

   // Array writes come either from a store hit at accept or from a completed fill
   always_comb begin
      wr_en   = 1'b0;
      wr_way  = hit_way;
      wr_set  = req_set;
      wr_tag  = req_tag;
      wr_data = req_wdata;
      use_en  = 1'b0;
      use_way = hit_way;
      use_set = req_set;
      if (accept && hit_any) begin
         use_en = 1'b1;
         wr_en  = req_write;
      end else if (fill_done) begin
         wr_en   = 1'b1;
         wr_way  = victim;
         wr_set  = lat_set;
         wr_tag  = lat_tag;
         wr_data = mem_rdata;
         use_en  = 1'b1;
         use_way = victim;
         use_set = lat_set;
      end
   end

   dcache_arrays u_arrays (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_set  (rd_set),
      .rd_data (set_rd),
      .wr_en   (wr_en),
      .wr_way  (wr_way),
      .wr_set  (wr_set),
      .wr_tag  (wr_tag),
      .wr_data (wr_data),
      .use_en  (use_en),
      .use_way (use_way),
      .use_set (use_set)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata <= req_wdata;
                  if (req_write) begin
                     state   <= ST_WTHRU;
                     mem_req <= 1'b1;
                     mem_we  <= 1'b1;
                  end else if (hit_any) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= hit_way0 ? set_rd.way[0].data : set_rd.way[1].data;
                  end else begin
                     state   <= ST_FILL;
                     mem_req <= 1'b1;
                     mem_we  <= 1'b0;
                  end
               end
            end
            ST_FILL: begin
               if (mem_ack) begin
                  state      <= ST_RESP;
                  mem_req    <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= mem_rdata;
               end
            end
            ST_WTHRU: begin
               if (mem_ack) begin
                  state      <= ST_RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  resp_valid <= 1'b1;
               end
            end
            default: begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
